fp_mul_arbiter: RTL
===================

# fp_mul_arbiter

Two-requester round-robin scheduler and sequencer for the shared single-precision combinational multiplier (`fp_X`/`fp_Y`/`r_mode` in, `fp_Z`/`ovrf`/`udrf` out). It accepts operand requests over valid/ready handshakes and registers the chosen operands so the multiplier inputs are stable for a full cycle. It captures the multiplier result and returns it, tagged with the requester id, over a valid/ready result channel with backpressure. It sits between the issue logic of two FP consumers and the single `fp_mul` instance.

## Interface
- `RM_W`, default 3: rounding-mode width. Encodings: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: bit i means requester i presents operands.
- `req_ready` out 2: bit i means requester i is granted; the transfer occurs when `req_valid[i] & req_ready[i]`.
- `req0_x`, `req0_y` in 32: requester 0 operands.
- `req0_rm` in `RM_W`: requester 0 rounding mode.
- `req1_x`, `req1_y` in 32: requester 1 operands.
- `req1_rm` in `RM_W`: requester 1 rounding mode.
- `mul_x`, `mul_y` out 32: driven to the multiplier's `fp_X`/`fp_Y`.
- `mul_rm` out `RM_W`: driven to the multiplier's `r_mode`.
- `mul_z` in 32: from the multiplier's `fp_Z`.
- `mul_ovrf`, `mul_udrf` in 1: from the multiplier's `ovrf`/`udrf`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_id` out 1: requester that owns the result.
- `res_z` out 32: registered product.
- `res_ovrf`, `res_udrf` out 1: registered multiplier flags.
- `flag_ovrf`, `flag_udrf` out 2: per-requester sticky flags (see Configuration).
- `flag_clr` in 2: bit i clears the sticky flags of requester i.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - `req_ready` is one-hot to the arbitration winner, or 00 if no request is valid.
  - On a transfer: latch x, y, rm and id into the operand register, update the pointer, go to CALC.
- CALC:
  - `req_ready`=00.
  - The operand register drives `mul_*`.
  - At the end of the cycle, capture `mul_z`/`mul_ovrf`/`mul_udrf` into the result register, then go to DONE.
- DONE:
  - `res_valid`=1; the result register is held stable until `res_ready`.
  - `req_ready` is the arbitration winner gated by `res_ready`.
  - `res_ready` with a transfer: latch the new operands and go to CALC (back-to-back).
  - `res_ready` with no transfer: go to IDLE.
  - No `res_ready`: stay in DONE with `req_ready`=00.
- Arbitration:
  - One-bit pointer `last`; the reset value 1 makes requester 0 win first.
  - Single valid requester: it wins.
  - Both valid: the requester ≠ `last` wins.
  - `last` updates only on a completed transfer. A grant without `req_valid` never occurs.
- Rounding mode: `req*_rm` values 101–111 are substituted with 000 (RNE) when latched.
- `mul_x`, `mul_y`, `mul_rm` always reflect the operand register, which holds its last value outside CALC. No combinational path runs from `req*` to `mul_*`.
- Reset values:
  - FSM IDLE, `last`=1.
  - Operand and result registers 0, so `mul_*`=0, `res_z`=0, `res_ovrf`=0, `res_udrf`=0, `res_id`=0.
  - `res_valid`=0, `req_ready`=00, `flag_*`=00.
- Reset mid-operation (CALC or DONE): the in-flight result is discarded; the next cycle is IDLE with reset values and no `res_valid`.

## Timing
- Accept in cycle t, CALC in t+1, `res_valid`=1 from t+2.
- Minimum latency is 2 cycles. Peak throughput is one result per 2 cycles (DONE→CALC overlap).
- `req_ready` depends combinationally on `req_valid`, the FSM state and `res_ready`. All other outputs are registered.
- While `res_valid`=1 and `res_ready`=0, `res_*` are constant and `req_ready`=00.
- The multiplier path is budgeted for one full cycle (operand register to result register).

## Configuration
- Macro: `FP_MUL_ARB_STICKY_FLAGS_EN`.
- Defined:
  - `flag_ovrf[i]`/`flag_udrf[i]` set on the cycle after a result handshake (`res_valid & res_ready`) with `res_id`=i and the respective flag=1.
  - They stay set until `flag_clr[i]`.
  - Same-cycle set and clear: the set wins.
- Undefined: `flag_ovrf`/`flag_udrf` are tied to 00, `flag_clr` is ignored, and no flag registers exist.

## Test plan
- Directed multiply:
  - Stimulus: after reset, req0 x=0x40400000, y=0x40400000, rm=001, `res_ready`=1.
  - Response: `req_ready`=01 in t; `res_valid`=1 at t+2 with `res_z`=0x41100000, `res_id`=0.
- Simultaneous requests:
  - Stimulus: both requesters valid continuously with `res_ready`=1.
  - Response: grants alternate 0,1,0,1; results return in order with ids 0,1,0,1 every 2 cycles.
- Backpressure:
  - Stimulus: hold `res_ready`=0 for 5 cycles in DONE.
  - Response: `res_z`/`res_id` are stable and `req_ready`=00 throughout. On release, back-to-back acceptance goes to CALC in the same cycle.
- Invalid rounding mode:
  - Stimulus: req1 with rm=111.
  - Response: `mul_rm`=000 during CALC.
- Sticky flags (macro defined):
  - Stimulus: req1 x=0x7f000000, y=0x7f000000; later pulse `flag_clr`=10.
  - Response: `res_ovrf`=1 and `flag_ovrf`=10 after the handshake. Returns to 00 the cycle after `flag_clr`=10. `flag_ovrf[0]` is untouched.
- Reset during CALC:
  - Stimulus: assert `rst` for 1 cycle.
  - Response: next cycle `res_valid`=0 and `req_ready`=00. With both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Two-requester round-robin sequencer for a shared combinational fp_mul instance.
// Define FP_MUL_ARB_STICKY_FLAGS_EN to build the per-requester sticky ovrf/udrf flags.
module fp_mul_arbiter #(
  parameter int unsigned RM_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [31:0]     req0_x,
  input  logic [31:0]     req0_y,
  input  logic [RM_W-1:0] req0_rm,
  input  logic [31:0]     req1_x,
  input  logic [31:0]     req1_y,
  input  logic [RM_W-1:0] req1_rm,
  output logic [31:0]     mul_x,
  output logic [31:0]     mul_y,
  output logic [RM_W-1:0] mul_rm,
  input  logic [31:0]     mul_z,
  input  logic            mul_ovrf,
  input  logic            mul_udrf,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_id,
  output logic [31:0]     res_z,
  output logic            res_ovrf,
  output logic            res_udrf,
  output logic [1:0]      flag_ovrf,
  output logic [1:0]      flag_udrf,
  input  logic [1:0]      flag_clr
);

  localparam int unsigned DW     = 32;
  localparam int unsigned RM_MAX = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic            id;
    logic [RM_W-1:0] rm;
    logic [DW-1:0]   x;
    logic [DW-1:0]   y;
  } op_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last;
  op_t             r_op;
  op_t             w_op_nxt;
  logic            w_win;
  logic            w_gate;
  logic            w_xfer;
  logic [RM_W-1:0] w_rm_sel;

  logic            r_res_valid;
  logic            r_res_id;
  logic [DW-1:0]   r_res_z;
  logic            r_res_ovrf;
  logic            r_res_udrf;

  // Round-robin pick: a lone requester wins, on contention the one not served last
  always_comb begin
    w_win = 1'b0;
    case (req_valid)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  // Operand capture with reserved rounding modes folded to RNE
  always_comb begin
    w_rm_sel      = w_win ? req1_rm : req0_rm;
    w_op_nxt.id   = w_win;
    w_op_nxt.x    = w_win ? req1_x : req0_x;
    w_op_nxt.y    = w_win ? req1_y : req0_y;
    w_op_nxt.rm   = (w_rm_sel > RM_W'(RM_MAX)) ? '0 : w_rm_sel;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gate      = 1'b0;
    req_ready   = 2'b00;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE:    w_gate = 1'b1;
      DONE:    w_gate = res_ready;
      default: w_gate = 1'b0;
    endcase
    if (w_gate && !rst && (req_valid != 2'b00)) begin
      req_ready = w_win ? 2'b10 : 2'b01;
      w_xfer    = 1'b1;
    end
    case (r_state)
      IDLE: if (w_xfer) w_state_nxt = CALC;
      CALC: w_state_nxt = DONE;
      DONE: if (res_ready) w_state_nxt = w_xfer ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_op        <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_z     <= '0;
      r_res_ovrf  <= 1'b0;
      r_res_udrf  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_res_valid <= (w_state_nxt == DONE);
      if (w_xfer) begin
        r_op   <= w_op_nxt;
        r_last <= w_win;
      end
      if (r_state == CALC) begin
        r_res_id   <= r_op.id;
        r_res_z    <= mul_z;
        r_res_ovrf <= mul_ovrf;
        r_res_udrf <= mul_udrf;
      end
    end
  end

  assign mul_x     = r_op.x;
  assign mul_y     = r_op.y;
  assign mul_rm    = r_op.rm;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_z     = r_res_z;
  assign res_ovrf  = r_res_ovrf;
  assign res_udrf  = r_res_udrf;

`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
  logic [1:0] r_flag_ovrf;
  logic [1:0] r_flag_udrf;
  logic [1:0] w_hs_sel;
  logic [1:0] w_set_ovrf;
  logic [1:0] w_set_udrf;

  // Set on an accepted result for its owner; set beats a same-cycle clear
  assign w_hs_sel   = (r_res_valid && res_ready) ? {r_res_id, ~r_res_id} : 2'b00;
  assign w_set_ovrf = w_hs_sel & {2{r_res_ovrf}};
  assign w_set_udrf = w_hs_sel & {2{r_res_udrf}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_ovrf <= 2'b00;
      r_flag_udrf <= 2'b00;
    end else begin
      r_flag_ovrf <= (r_flag_ovrf & ~flag_clr) | w_set_ovrf;
      r_flag_udrf <= (r_flag_udrf & ~flag_clr) | w_set_udrf;
    end
  end

  assign flag_ovrf = r_flag_ovrf;
  assign flag_udrf = r_flag_udrf;
`else
  logic w_unused_flag_clr;

  assign w_unused_flag_clr = ^flag_clr;
  assign flag_ovrf         = 2'b00;
  assign flag_udrf         = 2'b00;
`endif

endmodule
